// File: rtl/enable_register.sv
// enable_register
//   Generic WIDTH-bit register with a load enable and a synchronous,
//   active-high reset. It is intended as the pipeline and I/O staging
//   register of datapath blocks, where WIDTH is the only parameter that
//   normally needs setting.
//
//   Ports
//     clk  in   1      rising-edge clock, the only clock of the block
//     rst  in   1      synchronous active-high reset; loads RESET_VALUE
//     en   in   1      load enable, active-high
//     d    in   WIDTH  data captured when en=1 and rst=0
//     q    out  WIDTH  registered data, driven straight from the flops
//
//   Parameters
//     WIDTH        bit width of d and q (default 8)
//     RESET_VALUE  value taken by q at a reset edge (default all-zeros)
//     CHECK_PARAM  nonzero enables the elaboration-time parameter check
module enable_register #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CHECK_PARAM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Elaboration-only check: it produces no hardware, so synthesis never
  // sees it once parameters are legal.
  generate
    if ((CHECK_PARAM != 0) && (WIDTH < 1)) begin : g_param_check
      $fatal(1, "enable_register: parameter check WIDTH >= 1 failed");
    end
  endgenerate

  // Reset dominates the enable; with neither asserted the flops hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_enable_register.sv
// tb_enable_register
//   Directed and randomised checks of enable_register in two builds:
//   the default 8-bit zero-reset register (dut_a) and a 16-bit register
//   with RESET_VALUE 16'hBEEF (dut_b).
module tb_enable_register;

  logic        clk;
  logic        rst_a, en_a;
  logic [7:0]  d_a, q_a;
  logic        rst_b, en_b;
  logic [15:0] d_b, q_b;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model_a;

  enable_register dut_a (
    .clk (clk),
    .rst (rst_a),
    .en  (en_a),
    .d   (d_a),
    .q   (q_a)
  );

  enable_register #(
    .WIDTH       (16),
    .RESET_VALUE (16'hBEEF)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .en  (en_b),
    .d   (d_b),
    .q   (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset dominates an asserted enable in both builds.
    rst_a = 1'b1; en_a = 1'b1; d_a = 8'hA5;
    rst_b = 1'b1; en_b = 1'b1; d_b = 16'h5678;
    tick();
    check("reset_a", {8'h00, q_a}, 16'h0000);
    check("reset_b", q_b, 16'hBEEF);

    // Load, then a mid-cycle change on d must not reach q.
    rst_a = 1'b0; en_a = 1'b1; d_a = 8'h3C;
    tick();
    check("load_a", {8'h00, q_a}, 16'h003C);
    d_a = 8'hFF;
    #2;
    check("midcycle_d", {8'h00, q_a}, 16'h003C);

    // Hold for three edges with en low.
    en_a = 1'b0; d_a = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_a", {8'h00, q_a}, 16'h003C);
    end

    // A reset pulse entirely between edges has no effect.
    #1; rst_a = 1'b1;
    #2; rst_a = 1'b0;
    #1;
    check("rst_glitch_now", {8'h00, q_a}, 16'h003C);
    tick();
    check("rst_glitch_edge", {8'h00, q_a}, 16'h003C);

    // Reset held across an edge clears q even with en high.
    rst_a = 1'b1; en_a = 1'b1; d_a = 8'h77;
    tick();
    check("sync_reset_a", {8'h00, q_a}, 16'h0000);

    // First edge after reset release with en high loads.
    rst_a = 1'b0; en_a = 1'b1; d_a = 8'h9A;
    tick();
    check("load_after_rst", {8'h00, q_a}, 16'h009A);

    // Wide build: load, hold, reset back to BEEF.
    rst_b = 1'b0; en_b = 1'b1; d_b = 16'h1234;
    tick();
    check("load_b", q_b, 16'h1234);
    en_b = 1'b0; d_b = 16'hFFFF;
    tick();
    check("hold_b", q_b, 16'h1234);
    rst_b = 1'b1; en_b = 1'b1; d_b = 16'h0F0F;
    tick();
    check("reset_dom_b", q_b, 16'hBEEF);
    rst_b = 1'b0; en_b = 1'b1; d_b = 16'hA5C3;
    tick();
    check("load_b2", q_b, 16'hA5C3);

    // Random rst/en/d against a reference model.
    model_a = 8'h9A;
    for (int i = 0; i < 1000; i++) begin
      rst_a = ($urandom_range(0, 7) == 0);
      en_a  = $urandom_range(0, 1) == 1;
      d_a   = 8'($urandom);
      tick();
      model_a = rst_a ? 8'h00 : (en_a ? d_a : model_a);
      check("random_a", {8'h00, q_a}, {8'h00, model_a});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
